// File: rtl/cu_pkg.sv
// Shared constants and the control bundle for the ID/EX control decoder.
// Mode, opcode, EXE command, condition codes and status-register bit indices.
package cu_pkg;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_EXT = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_MUL = 4'b0000;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_MUL = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef struct packed {
        logic       valid;
        logic [3:0] exe;
        logic       wb;
        logic       mr;
        logic       mw;
        logic       b;
        logic       s;
        logic       ill;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluator: (cond, {N,Z,C,V}) -> pass.
// Used by control_unit_pipe only when CU_COND_EN is defined.
module cond_check
    import cu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] sr_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = sr_i[SR_N];
    assign z = sr_i[SR_Z];
    assign c = sr_i[SR_C];
    assign v = sr_i[SR_V];

    always_comb begin
        pass_o = 1'b0;
        unique case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit_pipe.sv
// Registered ID/EX control decoder with multi-cycle MUL sequencing.
// Define CU_COND_EN to squash instructions whose ARM condition fails.
module control_unit_pipe
    import cu_pkg::*;
#(
    parameter int EXE_CMD_W = 4,
    parameter int MUL_LAT   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic [3:0]           op_code,
    input  logic                 s_in,
    input  logic [3:0]           cond,
    input  logic [3:0]           sr,
    input  logic                 freeze,
    input  logic                 flush,
    output logic                 stall_out,
    output logic                 out_valid,
    output logic [EXE_CMD_W-1:0] exe_cmd,
    output logic                 wb_en,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic                 b,
    output logic                 s_out,
    output logic                 mul_busy,
    output logic                 illegal
);

    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

    ctrl_t          dec;
    logic           dec_mul;
    ctrl_t          cap;
    logic           cap_mul;
    logic           pass;
    logic           advance;
    ctrl_t          ctrl_q, ctrl_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        dec       = CTRL_NOP;
        dec_mul   = 1'b0;
        dec.valid = 1'b1;
        unique case (mode)
            MODE_ALU: begin
                dec.wb = 1'b1;
                dec.s  = s_in;
                unique case (op_code)
                    OP_MOV: dec.exe = EXE_MOV;
                    OP_MVN: dec.exe = EXE_MVN;
                    OP_ADD: dec.exe = EXE_ADD;
                    OP_ADC: dec.exe = EXE_ADC;
                    OP_SUB: dec.exe = EXE_SUB;
                    OP_SBC: dec.exe = EXE_SBC;
                    OP_AND: dec.exe = EXE_AND;
                    OP_ORR: dec.exe = EXE_ORR;
                    OP_EOR: dec.exe = EXE_EOR;
                    OP_CMP: begin
                        dec.exe = EXE_SUB;
                        dec.wb  = 1'b0;
                    end
                    OP_TST: begin
                        dec.exe = EXE_AND;
                        dec.wb  = 1'b0;
                    end
                    default: begin
                        dec.wb  = 1'b0;
                        dec.s   = 1'b0;
                        dec.ill = 1'b1;
                    end
                endcase
            end
            MODE_MEM: begin
                dec.exe = EXE_ADD;
                dec.mr  = s_in;
                dec.wb  = s_in;
                dec.mw  = ~s_in;
            end
            MODE_BR: begin
                dec.b = 1'b1;
            end
            MODE_EXT: begin
                if (op_code == OP_MUL) begin
                    dec.exe = EXE_MUL;
                    dec.wb  = 1'b1;
                    dec_mul = 1'b1;
                end else begin
                    dec.ill = 1'b1;
                end
            end
        endcase
    end

`ifdef CU_COND_EN
    cond_check u_cond_check (
        .cond_i (cond),
        .sr_i   (sr),
        .pass_o (pass)
    );
`else
    logic unused_cond;
    assign pass        = 1'b1;
    assign unused_cond = ^{cond, sr};
`endif

    // Invalid or condition-failed slots become bubbles and never start a MUL.
    always_comb begin
        cap     = CTRL_NOP;
        cap_mul = 1'b0;
        if (in_valid && pass) begin
            cap     = dec;
            cap_mul = dec_mul;
        end
    end

    assign advance = ~freeze & (cnt_q == '0);

    always_comb begin
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        if (flush) begin
            ctrl_d = CTRL_NOP;
            cnt_d  = '0;
        end else if (advance) begin
            ctrl_d = cap;
            cnt_d  = cap_mul ? CNT_LOAD : '0;
        end else if ((cnt_q != '0) && !freeze) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_NOP;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stall_out    = (cnt_q != '0);
    assign mul_busy     = (cnt_q != '0);
    assign out_valid    = ctrl_q.valid;
    assign exe_cmd      = EXE_CMD_W'(ctrl_q.exe);
    assign wb_en        = ctrl_q.wb;
    assign mem_read_en  = ctrl_q.mr;
    assign mem_write_en = ctrl_q.mw;
    assign b            = ctrl_q.b;
    assign s_out        = ctrl_q.s;
    assign illegal      = ctrl_q.ill;

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Parametrised, registered successor to the ID-stage control decoder.
- Decodes mode/op_code/S into EXE control and captures it in an ID/EX control register with valid, freeze and flush.
- Adds a multi-cycle MUL with an internal latency counter and stall output, plus an illegal-op flag.
- Sits between the ID-stage field extractor and the EXE stage; the hazard unit drives freeze, and EXE drives flush.

Parameters:
- EXE_CMD_W, 4: width of exe_cmd. Must be >=4; the 4-bit codes are zero-extended.
- MUL_LAT, 3: number of EXE cycles a MUL occupies. Must be >=1. The counter width is derived internally as clog2(MUL_LAT+1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ID fields are a real instruction
- mode  in  2  instruction mode field
- op_code  in  4  opcode field
- s_in  in  1  S bit (load/store select for mode 01)
- cond  in  4  ARM condition field
- sr  in  4  status flags {N,Z,C,V}
- freeze  in  1  hazard hold; register keeps its contents
- flush  in  1  branch-taken squash
- stall_out  out  1  high while a MUL is still occupying EXE; upstream must hold its fields
- out_valid  out  1  registered control is live
- exe_cmd  out  EXE_CMD_W  ALU command
- wb_en, mem_read_en, mem_write_en, b, s_out  out  1 each  registered controls
- mul_busy  out  1  registered MUL currently in progress
- illegal  out  1  registered undefined-opcode flag

Behaviour:
- Decode table (combinational), mode 00, always sets wb_en=1 unless noted:
  - MOV 1101 -> exe 0001; MVN 1111 -> 1001; ADD 0100 -> 0010; ADC 0101 -> 0011
  - SUB 0010 -> 0100; SBC 0110 -> 0101; AND 0000 -> 0110; ORR 1100 -> 0111; EOR 0001 -> 1000
  - CMP 1010 -> 0100, wb_en=0; TST 1000 -> 0110, wb_en=0
- Other modes:
  - Mode 01: exe 0010. s_in=1 is LDR (mem_read_en=1, wb_en=1); s_in=0 is STR (mem_write_en=1).
  - Mode 10: b=1, all other controls 0.
  - Mode 11 op 0000: MUL, exe 1010, wb_en=1.
  - Any other mode 00/11 op: illegal=1, all controls 0.
- s_out: equals s_in for mode 00; 0 for all other modes.
- Advance: advance = ~freeze & (cnt==0).
  - On an advancing edge the register captures the decoded fields; out_valid takes in_valid.
  - If in_valid=0, a bubble is captured: all controls 0.
- Priority at each clock edge: rst > flush > hold (when advance=0).
  - Flush clears every output and cnt to 0, even while frozen or mid-MUL.
- MUL sequencing:
  - When a MUL is captured, cnt loads MUL_LAT-1. While cnt!=0: stall_out=1, mul_busy=1, cnt decrements each non-frozen cycle, and the register holds.
  - When cnt reaches 0, the next instruction is accepted on that edge.
  - MUL_LAT=1 behaves like a single-cycle op: stall_out is never asserted.
- Freeze during a MUL: cnt does not decrement.
- stall_out is combinational from cnt only, with no path from inputs.
- Latency: exactly 1 cycle from fields to registered control when not stalled.
- Reset: every output 0 and cnt=0 after the first rst edge. Reset mid-MUL drops the MUL.

Optional Feature:
- Macro: CU_COND_EN.
- When defined:
  - cond is evaluated against sr using the ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 counts as fail.
  - On failure, a bubble is captured (out_valid=0, controls 0, no MUL counter load).
- When undefined: cond and sr are ignored, and every valid instruction executes.

Decomposition:
- Package cu_pkg holds:
  - mode constants: MODE_ALU, MODE_MEM, MODE_BR, MODE_EXT
  - opcode constants
  - 4-bit EXE_* command codes
  - COND_* codes
  - SR bit indices
- Sub-module cond_check:
  - Combinational (cond, sr) -> pass.
  - Instantiated only under CU_COND_EN.

Test Plan:
1. ADD then CMP, no freeze/flush:
   - mode 00 op 0100 then op 1010, in_valid=1.
   - Next edges: exe_cmd=0010, wb_en=1; then exe_cmd=0100, wb_en=0; out_valid=1 both cycles.
2. MUL_LAT=3 MUL followed by ADD:
   - stall_out=1 for 2 cycles, mul_busy=1, exe_cmd=1010 held.
   - ADD captured on the third edge after the MUL.
3. Freeze=1 for 2 cycles holding LDR (mode 01, s_in=1):
   - Outputs stay mem_read_en=1, wb_en=1, exe 0010.
   - Then freeze=0, STR is captured: mem_write_en=1, wb_en=0.
4. Flush=1 together with freeze=1 mid-MUL:
   - Next edge: all outputs 0, stall_out=0.
   - Following ADD is accepted immediately.
5. Mode 00 op 0011 with in_valid=1:
   - illegal=1, wb_en=0, exe_cmd=0, out_valid=1.
   - rst=1 next cycle clears illegal.
6. (CU_COND_EN) cond=0000 (EQ) with sr=0000, then sr=0100:
   - First case: bubble, out_valid=0.
   - Second case: ADD issued, wb_en=1.
